// File: rtl/btn_debounce_pulse.sv
// Purpose: push-button conditioner; 2-flop synchronizer, debounce FSM with a
//          stability timer, and optional auto-repeat. Emits one-cycle pulses.
// Latency: press/release accepted STABLE_CYCLES+2 edges after a stable input.
// Backpressure: none; pulse is a fire-and-forget strobe (at most 1 per 2 cycles).
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   btn_in    - raw asynchronous button (1 = pressed)
//   repeat_en - synchronous enable for auto-repeat while held
//   pulse     - registered one-cycle count-enable strobe
//   level     - registered debounced button state
//   busy      - registered, high while debouncing (DEB_PRESS / DEB_RELEASE)
//   state     - FSM state for debug: IDLE=0, DEB_PRESS=1, HELD=2, DEB_RELEASE=3
module btn_debounce_pulse #(
    parameter int STABLE_CYCLES = 4,
    parameter int REPEAT_CYCLES = 8,
    parameter int TMR_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       repeat_en,
    output logic       pulse,
    output logic       level,
    output logic       busy,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] RPT_LAST = TMR_W'(REPEAT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] r_rpt;
    logic             r_pulse;
    logic             r_level;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [TMR_W-1:0] w_tmr_nxt;
    logic [TMR_W-1:0] w_rpt_nxt;
    logic             w_pulse_nxt;
    logic             w_level_nxt;
    logic             w_busy_nxt;

    // Synchronizer; only r_s2 is safe to use in the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= btn_in;
            r_s2 <= r_s1;
        end
    end

    // State, timers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_tmr   <= '0;
            r_rpt   <= '0;
            r_pulse <= 1'b0;
            r_level <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_rpt   <= w_rpt_nxt;
            r_pulse <= w_pulse_nxt;
            r_level <= w_level_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next state and timers. The stability timer counts consecutive cycles of
    // the candidate level; any disagreement drops back to the settled state.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_rpt_nxt   = r_rpt;
        case (r_state)
            IDLE: begin
                w_rpt_nxt = '0;
                if (r_s2) begin
                    w_state_nxt = DEB_PRESS;
                    w_tmr_nxt   = TMR_ONE;
                end else begin
                    w_tmr_nxt   = '0;
                end
            end
            DEB_PRESS: begin
                w_rpt_nxt = '0;
                if (!r_s2) begin
                    w_state_nxt = IDLE;
                    w_tmr_nxt   = '0;
                end else if (r_tmr == STB_LAST) begin
                    w_state_nxt = HELD;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt   = r_tmr + TMR_ONE;
                end
            end
            HELD: begin
                w_tmr_nxt = '0;
                if (!r_s2) begin
                    w_state_nxt = DEB_RELEASE;
                    w_tmr_nxt   = TMR_ONE;
                    w_rpt_nxt   = '0;
                end else if (repeat_en) begin
                    // Terminal compare wraps to 0 so the timer never overflows.
                    w_rpt_nxt = (r_rpt == RPT_LAST) ? '0 : r_rpt + TMR_ONE;
                end else begin
                    w_rpt_nxt = '0;
                end
            end
            DEB_RELEASE: begin
                w_rpt_nxt = '0;
                if (r_s2) begin
                    w_state_nxt = HELD;
                    w_tmr_nxt   = '0;
                end else if (r_tmr == STB_LAST) begin
                    w_state_nxt = IDLE;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt   = r_tmr + TMR_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tmr_nxt   = '0;
                w_rpt_nxt   = '0;
            end
        endcase
    end

    // Output decode; level only moves on an accepted press or release.
    always_comb begin
        w_pulse_nxt = 1'b0;
        w_level_nxt = r_level;
        case (r_state)
            DEB_PRESS: begin
                if (r_s2 && (r_tmr == STB_LAST)) begin
                    w_pulse_nxt = 1'b1;
                    w_level_nxt = 1'b1;
                end
            end
            HELD: begin
                if (r_s2 && repeat_en && (r_rpt == RPT_LAST)) begin
                    w_pulse_nxt = 1'b1;
                end
            end
            DEB_RELEASE: begin
                if (!r_s2 && (r_tmr == STB_LAST)) begin
                    w_level_nxt = 1'b0;
                end
            end
            default: begin
                w_pulse_nxt = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt == DEB_PRESS) || (w_state_nxt == DEB_RELEASE);
    end

    assign pulse = r_pulse;
    assign level = r_level;
    assign busy  = r_busy;
    assign state = r_state;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with default parameters
// (STABLE_CYCLES=4, REPEAT_CYCLES=8). Inputs change on the falling edge,
// outputs are sampled on the falling edge; "edge e" is the e-th rising edge
// after the stimulus pattern starts.
module tb_btn_debounce_pulse;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       repeat_en;
    logic       pulse;
    logic       level;
    logic       busy;
    logic [1:0] state;

    int n_vec;
    int n_err;

    btn_debounce_pulse #(
        .STABLE_CYCLES(4),
        .REPEAT_CYCLES(8),
        .TMR_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .repeat_en(repeat_en),
        .pulse    (pulse),
        .level    (level),
        .busy     (busy),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic go_idle;
        repeat_en = 1'b0;
        btn_in    = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_reset;
        logic [1:0] es;
        logic       ep;
        logic       el;
        @(negedge clk);
        n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
        n_vec++; if (pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse got %b want 0", pulse); end
        n_vec++; if (level !== 1'b0) begin n_err++; $display("FAIL reset_level got %b want 0", level); end
        n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        rst    = 1'b0;
        btn_in = 1'b1;
        repeat (4) tick();
        n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL pre_reset_state got %0d want 1", state); end
        // Asynchronous assert in the middle of a clock low phase.
        #2 rst = 1'b1;
        #1;
        n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL async_rst_state got %0d want 0", state); end
        n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL async_rst_busy got %b want 0", busy); end
        n_vec++; if (pulse !== 1'b0) begin n_err++; $display("FAIL async_rst_pulse got %b want 0", pulse); end
        n_vec++; if (level !== 1'b0) begin n_err++; $display("FAIL async_rst_level got %b want 0", level); end
        @(negedge clk);
        rst = 1'b0;
        // Button still high: full debounce restarts from the synchronizer.
        for (int e = 0; e < 8; e++) begin
            tick();
            es = (e < 2) ? 2'd0 : (e < 5) ? 2'd1 : 2'd2;
            ep = (e == 5);
            el = (e >= 5);
            n_vec++; if (state !== es) begin n_err++; $display("FAIL rst_restart_state e=%0d got %0d want %0d", e, state, es); end
            n_vec++; if (pulse !== ep) begin n_err++; $display("FAIL rst_restart_pulse e=%0d got %b want %b", e, pulse, ep); end
            n_vec++; if (level !== el) begin n_err++; $display("FAIL rst_restart_level e=%0d got %b want %b", e, level, el); end
        end
        // Reset while HELD clears level immediately.
        #2 rst = 1'b1;
        #1;
        n_vec++; if (level !== 1'b0) begin n_err++; $display("FAIL held_rst_level got %b want 0", level); end
        n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL held_rst_state got %0d want 0", state); end
        @(negedge clk);
        rst    = 1'b0;
        btn_in = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_clean_press;
        logic [1:0] es;
        logic       ep;
        logic       el;
        logic       eb;
        btn_in = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            es = (e < 2) ? 2'd0 : (e < 5) ? 2'd1 : 2'd2;
            ep = (e == 5);
            el = (e >= 5);
            eb = (e >= 2) && (e < 5);
            n_vec++; if (state !== es) begin n_err++; $display("FAIL press_state e=%0d got %0d want %0d", e, state, es); end
            n_vec++; if (pulse !== ep) begin n_err++; $display("FAIL press_pulse e=%0d got %b want %b", e, pulse, ep); end
            n_vec++; if (level !== el) begin n_err++; $display("FAIL press_level e=%0d got %b want %b", e, level, el); end
            n_vec++; if (busy !== eb)  begin n_err++; $display("FAIL press_busy e=%0d got %b want %b", e, busy, eb); end
        end
    endtask

    task automatic test_release_bounce;
        logic [1:0] es;
        logic       el;
        // Starts from HELD with btn high: low for 2 cycles, then high again.
        for (int e = 0; e < 10; e++) begin
            btn_in = (e >= 2);
            tick();
            es = (e < 2) ? 2'd2 : (e < 4) ? 2'd3 : 2'd2;
            n_vec++; if (state !== es)   begin n_err++; $display("FAIL relb_state e=%0d got %0d want %0d", e, state, es); end
            n_vec++; if (level !== 1'b1) begin n_err++; $display("FAIL relb_level e=%0d got %b want 1", e, level); end
            n_vec++; if (pulse !== 1'b0) begin n_err++; $display("FAIL relb_pulse e=%0d got %b want 0", e, pulse); end
        end
        // Steady low: accepted on the 6th edge.
        btn_in = 1'b0;
        for (int e = 0; e < 9; e++) begin
            tick();
            es = (e < 2) ? 2'd2 : (e < 5) ? 2'd3 : 2'd0;
            el = (e < 5);
            n_vec++; if (state !== es)   begin n_err++; $display("FAIL rel_state e=%0d got %0d want %0d", e, state, es); end
            n_vec++; if (level !== el)   begin n_err++; $display("FAIL rel_level e=%0d got %b want %b", e, level, el); end
            n_vec++; if (pulse !== 1'b0) begin n_err++; $display("FAIL rel_pulse e=%0d got %b want 0", e, pulse); end
        end
    endtask

    task automatic test_press_bounce;
        logic [1:0] es;
        logic       ep;
        // High 2, low 1, then steady high.
        for (int e = 0; e < 12; e++) begin
            btn_in = (e < 2) || (e >= 3);
            tick();
            es = (e < 2) ? 2'd0 : (e < 4) ? 2'd1 : (e == 4) ? 2'd0 : (e < 8) ? 2'd1 : 2'd2;
            ep = (e == 8);
            n_vec++; if (state !== es) begin n_err++; $display("FAIL pressb_state e=%0d got %0d want %0d", e, state, es); end
            n_vec++; if (pulse !== ep) begin n_err++; $display("FAIL pressb_pulse e=%0d got %b want %b", e, pulse, ep); end
        end
    endtask

    task automatic test_auto_repeat;
        logic [1:0] es;
        logic       ep;
        int         npulse;
        npulse = 0;
        btn_in = 1'b1;
        for (int e = 0; e < 86; e++) begin
            repeat_en = (e < 50) || (e >= 71);
            tick();
            es = (e < 2) ? 2'd0 : (e < 5) ? 2'd1 : 2'd2;
            ep = ((e >= 5) && (e <= 45) && (((e - 5) % 8) == 0)) || (e == 78);
            if (e <= 45 && pulse === 1'b1) npulse++;
            n_vec++; if (state !== es) begin n_err++; $display("FAIL rpt_state e=%0d got %0d want %0d", e, state, es); end
            n_vec++; if (pulse !== ep) begin n_err++; $display("FAIL rpt_pulse e=%0d got %b want %b", e, pulse, ep); end
        end
        n_vec++; if (npulse != 6) begin n_err++; $display("FAIL rpt_count got %0d want 6", npulse); end
    endtask

    task automatic test_counter;
        logic [2:0] cnt3;
        int         np;
        cnt3 = 3'd0;
        for (int p = 1; p <= 9; p++) begin
            np = 0;
            // Press with a leading glitch and a release glitch.
            for (int e = 0; e < 28; e++) begin
                btn_in = (e == 0) || ((e >= 2) && (e < 14)) || (e == 16);
                tick();
                if (pulse === 1'b1) begin
                    np++;
                    cnt3 = cnt3 + 3'd1;
                end
            end
            n_vec++; if (np != 1) begin n_err++; $display("FAIL cnt_press%0d_pulses got %0d want 1", p, np); end
            n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL cnt_press%0d_state got %0d want 0", p, state); end
            if (p == 7) begin
                n_vec++; if (cnt3 !== 3'd7) begin n_err++; $display("FAIL cnt_at7 got %0d want 7", cnt3); end
            end
            if (p == 8) begin
                n_vec++; if (cnt3 !== 3'd0) begin n_err++; $display("FAIL cnt_wrap got %0d want 0", cnt3); end
            end
        end
        n_vec++; if (cnt3 !== 3'd1) begin n_err++; $display("FAIL cnt_final got %0d want 1", cnt3); end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        btn_in    = 1'b0;
        repeat_en = 1'b0;
        test_reset();
        go_idle();
        test_clean_press();
        test_release_bounce();
        go_idle();
        test_press_bounce();
        go_idle();
        test_auto_repeat();
        go_idle();
        test_counter();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
- Upstream stage for the 3-bit up counter: turns a raw, bouncy push-button input into clean single-cycle count-enable pulses.
- Contains a 2-flop synchronizer, a debounce FSM with a stability timer, and an optional auto-repeat timer.
- `pulse` drives the counter's increment enable.
- `level` gives the debounced button state for status/LED use.

Parameters:
- STABLE_CYCLES, 4: consecutive synchronized cycles needed to accept a press or release; legal range ≥2.
- REPEAT_CYCLES, 8: cycles between auto-repeat pulses while held with repeat enabled; legal range ≥2.
- TMR_W, 8: width of both timers; must hold max(STABLE_CYCLES, REPEAT_CYCLES)-1.

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- btn_in, input, 1: raw asynchronous button; 1 = pressed.
- repeat_en, input, 1: synchronous; enables auto-repeat while held.
- pulse, output, 1: registered one-cycle count-enable strobe.
- level, output, 1: registered debounced button state.
- busy, output, 1: registered; 1 while in DEB_PRESS or DEB_RELEASE.
- state, output, 2: FSM state for debug. IDLE=0, DEB_PRESS=1, HELD=2, DEB_RELEASE=3.

Behaviour:
- Reset (async assert, any time, including mid-debounce): sync flops=0, state=IDLE, stability timer=0, repeat timer=0, pulse=0, level=0, busy=0.
  - Reset release takes effect at the next clk edge.
- Synchronizer: btn_in → s1 → s2. FSM uses s2 only; this adds 2 edges of latency.
- IDLE:
  - s2=1 → DEB_PRESS, timer=1.
  - Else stay; timer=0.
- DEB_PRESS:
  - s2=0 → IDLE, timer=0, no pulse (bounce rejected).
  - s2=1 and timer==STABLE_CYCLES-1 → HELD, timer=0, level=1, pulse=1 (press accepted).
  - s2=1 otherwise → timer+1.
- HELD:
  - s2=0 → DEB_RELEASE, timer=1, repeat timer=0.
  - s2=1 and repeat_en=1: repeat timer+1 each cycle. When it equals REPEAT_CYCLES-1: pulse=1, repeat timer=0.
  - s2=1 and repeat_en=0: repeat timer held at 0.
- DEB_RELEASE:
  - s2=1 → HELD, timer=0, level stays 1, no pulse (release bounce rejected).
  - s2=0 and timer==STABLE_CYCLES-1 → IDLE, level=0, timer=0.
  - s2=0 otherwise → timer+1.
- Pulse and level timing:
  - pulse is 0 in every cycle not listed above; never high for 2 consecutive cycles.
  - level changes only on accepted press/release.
- Press latency: btn_in stable high before edge E0 → pulse and level high after edge E(STABLE_CYCLES+1). Default: 6th edge.
- Release latency: same, STABLE_CYCLES+2 edges to level=0.
- busy = (state==DEB_PRESS) or (state==DEB_RELEASE), registered with state.
- repeat_en change mid-hold: deassert clears the repeat timer next edge; reassert restarts the count from 0.
- Timers never wrap; the terminal compare always fires first.

Test Plan:
- Reset check: assert rst mid-DEB_PRESS (btn held 2 cycles) → state=0, pulse=0, level=0, busy=0 immediately (async). After release with btn still high, a full STABLE_CYCLES debounce restarts.
- Clean press, STABLE_CYCLES=4: btn_in 0→1 before E0, held → pulse=1 exactly at E5–E6 (one cycle), level=1 from E5, busy=1 during E2–E4.
- Press bounce: btn_in high 2 cycles, low 1 cycle, then high steady → no pulse for the first burst; a single pulse 6 edges after the final rise.
- Release bounce: from HELD, btn_in low 2 cycles then high → returns to HELD, level stays 1, no pulse. Then a steady low for 6 edges → level=0, state=IDLE.
- Auto-repeat, repeat_en=1, REPEAT_CYCLES=8: hold btn 40 cycles → initial pulse at acceptance, then pulses every 8 cycles (5 pulses total within 40 cycles of HELD + initial). Dropping repeat_en stops further pulses next edge.
- Counter integration: btn_debounce_pulse.pulse drives the up counter's enable. 9 clean presses → counter value wraps 7→0 and ends at 1; no extra counts from bounces.
